// File: rtl/pdm_playback_modulator.sv
// Purpose : buffers 16-bit signed PCM in a small FIFO and turns it into a 1-bit PDM stream with a
//           second-order sigma-delta modulator, one PCM sample consumed every OSR clocks.
// Latency : a sample loads at the first load point (phase==OSR-1) after it is stored and first
//           affects pdm_out one clock after that load.
// Backpressure: pcm_in_ready drops while the FIFO is full or reset is high. An empty FIFO at a load
//           point plays zero and pulses underrun.
//
// Ports:
//   clk, reset        1.536 MHz system clock, synchronous active-high reset
//   pcm_in[15:0]      signed PCM sample, qualified by pcm_in_valid / pcm_in_ready
//   pdm_out           registered PDM bit, one per clk
//   sample_tick       one-cycle pulse at phase 0 after every load (sample or underrun zero)
//   underrun          one-cycle pulse at phase 0 when the FIFO was empty at the load point
//   fifo_level        FIFO occupancy after the previous edge
//
// Optional feature: define PDM_PLAYBACK_DITHER_EN to add a +/-1 LSB dither taken from a
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1). This breaks idle tones.

module pdm_playback_modulator #(
   parameter int OSR        = 96,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [15:0]                   pcm_in,
   input  logic                          pcm_in_valid,
   output logic                          pcm_in_ready,
   output logic                          pdm_out,
   output logic                          sample_tick,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = $clog2(OSR);

   // ---------------------------------------------------------------- FIFO
   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // ---------------------------------------------------------------- sequencing
   logic [PW-1:0]      phase;
   logic               load;
   logic signed [15:0] cur_sample;

   // ---------------------------------------------------------------- modulator
   logic signed [19:0] i1;
   logic signed [23:0] i2;
   logic signed [16:0] d;
   logic signed [16:0] x;
   logic signed [16:0] fb;
   logic signed [21:0] sum1;
   logic signed [25:0] sum2;
   logic signed [19:0] i1_n;
   logic signed [23:0] i2_n;

   function automatic logic signed [19:0] sat20(input logic signed [21:0] v);
      if (v > 22'sd524287)
         sat20 = 20'h7FFFF;
      else if (v < -22'sd524288)
         sat20 = 20'h80000;
      else
         sat20 = v[19:0];
   endfunction

   function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
      if (v > 26'sd8388607)
         sat24 = 24'h7FFFFF;
      else if (v < -26'sd8388608)
         sat24 = 24'h800000;
      else
         sat24 = v[23:0];
   endfunction

   assign full         = (count == LW'(FIFO_DEPTH));
   assign empty        = (count == '0);
   assign pcm_in_ready = !full && !reset;
   assign push         = pcm_in_valid && pcm_in_ready;
   assign load         = (phase == PW'(OSR - 1));
   // Emptiness is judged on registered state only: a same-cycle push never rescues a load.
   assign pop          = load && !empty;
   assign fifo_level   = count;

`ifdef PDM_PLAYBACK_DITHER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= 16'hACE1;
      else
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   assign d = lfsr[0] ? 17'sd1 : -17'sd1;
`else
   assign d = '0;
`endif

   // Feedback is +/- full scale; the width casts sign-extend every operand before the adds.
   assign fb   = pdm_out ? 17'sd32768 : -17'sd32768;
   assign x    = 17'(cur_sample) + d;
   assign sum1 = 22'(i1) + 22'(x) - 22'(fb);
   assign i1_n = sat20(sum1);
   assign sum2 = 26'(i2) + 26'(i1_n) - 26'(fb);
   assign i2_n = sat24(sum2);

   // Storage array carries no reset; clearing the pointers and count discards its contents.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= pcm_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         phase       <= '0;
         cur_sample  <= '0;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
         i1          <= '0;
         i2          <= '0;
         pdm_out     <= 1'b0;
      end else begin
         i1      <= i1_n;
         i2      <= i2_n;
         pdm_out <= !i2_n[23];

         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);

         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase

         if (load) begin
            phase       <= '0;
            sample_tick <= 1'b1;
            underrun    <= empty;
            cur_sample  <= empty ? 16'sd0 : $signed(mem[rd_ptr]);
         end else begin
            phase       <= phase + PW'(1);
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pdm_playback_modulator.sv
module tb_pdm_playback_modulator;

   localparam int OSR   = 96;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pcm_in;
   logic        pcm_in_valid;
   logic        pcm_in_ready;
   logic        pdm_out;
   logic        sample_tick;
   logic        underrun;
   logic [2:0]  fifo_level;

   always #5 clk = ~clk;

   pdm_playback_modulator #(.OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .pcm_in       (pcm_in),
      .pcm_in_valid (pcm_in_valid),
      .pcm_in_ready (pcm_in_ready),
      .pdm_out      (pdm_out),
      .sample_tick  (sample_tick),
      .underrun     (underrun),
      .fifo_level   (fifo_level)
   );

   int errors = 0;
   int checks = 0;
   bit accepted;

   // Behavioural model: integer arithmetic, a queue for the FIFO, a phase count.
   int      m_phase;
   int      m_q[$];
   int      m_cur;
   longint  m_i1, m_i2;
   bit      m_pdm, m_tick, m_unf;
   bit [15:0] m_lfsr;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic longint clamp(input longint v, input int n);
      longint hi, lo;
      hi = (longint'(1) << (n - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic model_update(input bit r, input bit v, input int dat);
      longint fb, x;
      int dith;
      bit was_full;
      if (r) begin
         m_phase = 0; m_q.delete(); m_cur = 0; m_i1 = 0; m_i2 = 0;
         m_pdm = 0; m_tick = 0; m_unf = 0; m_lfsr = 16'hACE1;
         return;
      end
      was_full = (m_q.size() >= DEPTH);
      dith = 0;
`ifdef PDM_PLAYBACK_DITHER_EN
      dith = m_lfsr[0] ? 1 : -1;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
      fb    = m_pdm ? 32768 : -32768;
      x     = m_cur + dith;
      m_i1  = clamp(m_i1 + x - fb, 20);
      m_i2  = clamp(m_i2 + m_i1 - fb, 24);
      m_pdm = (m_i2 >= 0);
      if (m_phase == OSR - 1) begin
         m_phase = 0;
         m_tick  = 1;
         if (m_q.size() == 0) begin
            m_cur = 0;
            m_unf = 1;
         end else begin
            m_cur = m_q.pop_front();
            m_unf = 0;
         end
      end else begin
         m_phase++;
         m_tick = 0;
         m_unf  = 0;
      end
      if (v && !was_full)
         m_q.push_back(dat);
   endtask

   task automatic check_state();
      chk("pdm_out",     pdm_out,     m_pdm);
      chk("sample_tick", sample_tick, m_tick);
      chk("underrun",    underrun,    m_unf);
      chk("fifo_level",  fifo_level,  m_q.size());
      chk("i1",          $signed(dut.i1), m_i1);
      chk("i2",          $signed(dut.i2), m_i2);
   endtask

   // Called at a negedge: drive inputs for the coming edge, check ready, advance model, check outputs.
   task automatic step(input bit r, input bit v, input logic [15:0] dat);
      bit exp_rdy;
      reset = r; pcm_in_valid = v; pcm_in = dat;
      #1;
      exp_rdy = !r && (m_q.size() < DEPTH);
      chk("pcm_in_ready", pcm_in_ready, exp_rdy);
      accepted = v && exp_rdy;
      model_update(r, v, int'($signed(dat)));
      @(negedge clk);
      check_state();
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 16'h0000);
         chk("rst_pdm", pdm_out, 0);
         chk("rst_level", fifo_level, 0);
         chk("rst_underrun", underrun, 0);
         chk("rst_ready", pcm_in_ready, 0);
      end
   endtask

   task automatic run_dc(input string name, input logic [15:0] val, input int lo, input int hi);
      int ones;
      ones = 0;
      do_reset();
      for (int c = 0; c < 192 + 9600; c++) begin
         if (c >= 192) ones += int'(pdm_out);
         step(1'b0, 1'b1, val);
      end
      chk_range(name, ones, lo, hi);
   endtask

   typedef struct {
      int cyc;
      bit rdy;
      int lvl;
      bit tick;
      bit unf;
      bit chk_cur;
      int cur;
   } vec_t;

   vec_t tbl [14];

   initial begin
      int nxt, idx, ones, win, unf_a, unf_b, tot, c;
      logic [15:0] rv;
      bit r, v;

      tbl[0]  = '{1,   1, 1, 0, 0, 0, 0};
      tbl[1]  = '{3,   1, 3, 0, 0, 0, 0};
      tbl[2]  = '{4,   0, 4, 0, 0, 0, 0};
      tbl[3]  = '{95,  0, 4, 0, 0, 1, 0};
      tbl[4]  = '{96,  1, 3, 1, 0, 1, 1};
      tbl[5]  = '{97,  0, 4, 0, 0, 1, 1};
      tbl[6]  = '{191, 0, 4, 0, 0, 1, 1};
      tbl[7]  = '{192, 1, 3, 1, 0, 1, 2};
      tbl[8]  = '{288, 1, 2, 1, 0, 1, 3};
      tbl[9]  = '{384, 1, 1, 1, 0, 1, 4};
      tbl[10] = '{480, 1, 0, 1, 0, 1, 5};
      tbl[11] = '{481, 1, 0, 0, 0, 1, 5};
      tbl[12] = '{576, 1, 0, 1, 1, 1, 0};
      tbl[13] = '{577, 1, 0, 0, 0, 1, 0};

      reset = 1'b1; pcm_in_valid = 1'b0; pcm_in = '0;
      model_update(1'b1, 1'b0, 0);
      @(negedge clk);

      // Reset, then hold valid with 1..5 to exercise backpressure and pop order.
      do_reset();
      nxt = 1; idx = 0;
      for (int k = 0; k <= 600; k++) begin
         if (idx < 14 && tbl[idx].cyc == k) begin
            chk($sformatf("tbl%0d_ready", k), pcm_in_ready, tbl[idx].rdy);
            chk($sformatf("tbl%0d_level", k), fifo_level,   tbl[idx].lvl);
            chk($sformatf("tbl%0d_tick", k),  sample_tick,  tbl[idx].tick);
            chk($sformatf("tbl%0d_unf", k),   underrun,     tbl[idx].unf);
            if (tbl[idx].chk_cur)
               chk($sformatf("tbl%0d_cur", k), $signed(dut.cur_sample), tbl[idx].cur);
            idx++;
         end
         step(1'b0, nxt <= 5, 16'(nxt));
         if (accepted) nxt++;
      end
      chk("tbl_visited", idx, 14);

      // Silence: exact 50% density per 960-cycle window, no underrun.
      do_reset();
      win = 0; unf_a = 0;
      for (int k = 0; k < 192 + 3 * 960; k++) begin
         unf_a += int'(underrun);
         if (k >= 192) begin
            win += int'(pdm_out);
            if ((k - 192) % 960 == 959) begin
               chk_range("silence_window", win, 478, 482);
               win = 0;
            end
         end
         step(1'b0, 1'b1, 16'h0000);
      end
      chk("silence_underruns", unf_a, 0);

      // DC levels.
      run_dc("dc_pos_density", 16'sd16384,  7104, 7296);
      run_dc("dc_neg_density", -16'sd16384, 2304, 2496);

      // Underrun: a single sample, then starvation, then continuous feed.
      do_reset();
      unf_a = 0; unf_b = 0;
      for (int k = 0; k <= 700; k++) begin
         if (k == 96)  chk("unf_first_cur", $signed(dut.cur_sample), 16384);
         if (k == 192) begin
            chk("unf_pulse", underrun, 1);
            chk("unf_cur_zero", $signed(dut.cur_sample), 0);
         end
         if (k == 193) chk("unf_pulse_end", underrun, 0);
         if (k <= 200) unf_a += int'(underrun);
         else          unf_b += int'(underrun);
         step(1'b0, (k == 0) || (k >= 200), 16'h4000);
      end
      chk("unf_count_starved", unf_a, 1);
      chk("unf_count_resumed", unf_b, 0);

      // Full scale, then reset at phase 50.
      do_reset();
      ones = 0; tot = 0; c = 0;
      while (!(c >= 2000 && c % OSR == 50)) begin
         if (c >= 192 && c < 2000) begin
            ones += int'(pdm_out);
            tot++;
         end
         step(1'b0, 1'b1, 16'h7FFF);
         c++;
      end
      checks++;
      if (ones * 100 < tot * 99) begin
         errors++;
         $display("FAIL fs_density: got %0d ones of %0d expected at least 99%%", ones, tot);
      end
      chk("fs_phase_before_reset", dut.phase, 50);
      step(1'b1, 1'b1, 16'h7FFF);
      chk("fs_rst_phase", dut.phase, 0);
      chk("fs_rst_cur", $signed(dut.cur_sample), 0);
      chk("fs_rst_i1", $signed(dut.i1), 0);
      chk("fs_rst_i2", $signed(dut.i2), 0);
      chk("fs_rst_pdm", pdm_out, 0);
      chk("fs_rst_level", fifo_level, 0);
      chk("fs_rst_tick", sample_tick, 0);
      chk("fs_rst_unf", underrun, 0);
      unf_a = 0;
      for (int k = 0; k < 60; k++) begin
         unf_a += int'(underrun);
         step(1'b0, 1'b1, 16'h1234);
      end
      chk("fs_no_unf_after_reset", unf_a, 0);

      // Randomised traffic against the model, with occasional resets and bursty gaps.
      do_reset();
      for (int k = 0; k < 4000; k++) begin
         r = ($urandom_range(0, 799) == 0);
         v = ((k / 150) % 3 == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 4))
            0:       rv = 16'h7FFF;
            1:       rv = 16'h8000;
            2:       rv = 16'h0000;
            default: rv = 16'($urandom);
         endcase
         step(r, v, rv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
